// File: rtl/dmem_access_unit.sv
// Memory-stage load/store initiator for a word-addressed data memory.
// Sub-word stores use read-modify-write; bad requests fault without touching memory.
module dmem_access_unit #(
    parameter int MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_fault,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR} state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic        read_q;
    logic        write_q;

    logic        req_fault;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign req_ready = (state == IDLE);
    // Strobes are gated by reset so an abandoned RMW never commits on the reset edge.
    assign mem_read  = read_q & rst_n;
    assign mem_write = write_q & rst_n;

    always_comb begin
        req_fault = 1'b0;
        case (req_funct3)
            3'b000:  req_fault = 1'b0;
            3'b001:  req_fault = req_addr[0];
            3'b010:  req_fault = (req_addr[1:0] != 2'b00);
            3'b100:  req_fault = req_we;
            3'b101:  req_fault = req_we | req_addr[0];
            default: req_fault = 1'b1;
        endcase
        if (req_addr[31:2] >= 30'(MEM_WORDS))
            req_fault = 1'b1;
    end

    always_comb begin
        lane_b = mem_rdata[7:0];
        case (lane_q)
            2'd0: lane_b = mem_rdata[7:0];
            2'd1: lane_b = mem_rdata[15:8];
            2'd2: lane_b = mem_rdata[23:16];
            2'd3: lane_b = mem_rdata[31:24];
            default: lane_b = mem_rdata[7:0];
        endcase
        lane_h = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
            3'b100:  load_data = {24'b0, lane_b};
            3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
            3'b101:  load_data = {16'b0, lane_h};
            default: load_data = mem_rdata;
        endcase
    end

    // Merge the store lane into the word just read (SB when funct3[0]=0, SH otherwise).
    always_comb begin
        merged = mem_rdata;
        if (!funct3_q[0]) begin
            case (lane_q)
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = mem_rdata;
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            lane_q     <= 2'b00;
            wdata_q    <= 16'h0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rdata <= 32'h0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
        end else begin
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rdata <= 32'h0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        lane_q   <= req_addr[1:0];
                        wdata_q  <= req_wdata[15:0];
                        if (req_fault) begin
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                        end else begin
                            state    <= ACCESS;
                            mem_addr <= {2'b00, req_addr[31:2]};
                            if (req_we && req_funct3 == 3'b010) begin
                                write_q   <= 1'b1;
                                mem_wdata <= req_wdata;
                            end else begin
                                read_q <= 1'b1;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        read_q     <= 1'b0;
                        resp_rdata <= load_data;
                        resp_valid <= 1'b1;
                        state      <= IDLE;
                    end else if (funct3_q == 3'b010) begin
                        write_q    <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        read_q    <= 1'b0;
                        write_q   <= 1'b1;
                        mem_wdata <= merged;
                        state     <= MERGE_WR;
                    end
                end
                MERGE_WR: begin
                    write_q    <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit with a behavioural word memory
// and a response scoreboard that also checks response cycle.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_fault;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:31];
    logic        preload = 1'b1;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct packed {
        logic        fault;
        logic [31:0] rdata;
        logic [31:0] due;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    dmem_access_unit #(.MEM_WORDS(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_fault (resp_fault),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural responder: combinational read, write commits on the clock edge.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0000006E;
        end else if (mem_write && mem_addr < 32) begin
            mem[mem_addr[4:0]] <= mem_wdata;
        end
    end

    assign mem_rdata = (mem_read && mem_addr < 32) ? mem[mem_addr[4:0]] : 32'h0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic driveReq(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
    endtask

    // Called at a falling edge; returns at the falling edge of cycle 1 after accept.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic exp_fault,
                                 input logic [31:0] exp_rdata, input int lat,
                                 input logic exp_rd, input logic exp_wr);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) checkOutput("ready_wait", 32'd0, 32'd1);
        driveReq(we, f3, addr, wdata);
        sb_q.push_back('{fault: exp_fault, rdata: exp_rdata, due: 32'(cyc + lat)});
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_wdata = 32'hA5A5A5A5;
        req_addr  = 32'hFFFFFFFF;
        @(negedge clk);
        checkOutput("rd_strobe", {31'b0, mem_read}, {31'b0, exp_rd});
        checkOutput("wr_strobe", {31'b0, mem_write}, {31'b0, exp_wr});
        if (exp_rd || exp_wr) checkOutput("mem_addr", mem_addr, {2'b00, addr[31:2]});
    endtask

    // Scoreboard consumer: every resp_valid must match the oldest expectation and its cycle.
    always @(negedge clk) begin
        if (rst_n) checkOutput("strobe_excl", {31'b0, mem_read & mem_write}, 32'd0);
        if (resp_valid) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_resp", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("resp_fault", {31'b0, resp_fault}, {31'b0, mon_e.fault});
                checkOutput("resp_rdata", resp_rdata, mon_e.rdata);
                checkOutput("resp_cycle", 32'(cyc), mon_e.due);
            end
        end
    end

    initial begin
        int n;
        $display("[TB] start");
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        preload = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("rst_resp_fault", {31'b0, resp_fault}, 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_mem_read", {31'b0, mem_read}, 32'd0);
        checkOutput("rst_mem_write", {31'b0, mem_write}, 32'd0);

        // Plain word load from preset memory
        applyStimulus(1'b0, 3'b010, 32'h8, 32'h0, 1'b0, 32'h0000006E, 2, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("lw_read_one_cycle", {31'b0, mem_read}, 32'd0);

        // Word store, then byte/half loads with sign and zero extension
        applyStimulus(1'b1, 3'b010, 32'h4, 32'hDEADBEEF, 1'b0, 32'h0, 2, 1'b0, 1'b1);
        checkOutput("sw_wdata", mem_wdata, 32'hDEADBEEF);
        applyStimulus(1'b0, 3'b000, 32'h7, 32'h0, 1'b0, 32'hFFFFFFDE, 2, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'b100, 32'h7, 32'h0, 1'b0, 32'h000000DE, 2, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'b001, 32'h4, 32'h0, 1'b0, 32'hFFFFBEEF, 2, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'b101, 32'h6, 32'h0, 1'b0, 32'h0000DEAD, 2, 1'b1, 1'b0);

        // Read-modify-write sub-word stores
        applyStimulus(1'b1, 3'b000, 32'h5, 32'h123456AB, 1'b0, 32'h0, 3, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("sb_merge_write", {31'b0, mem_write}, 32'd1);
        checkOutput("sb_merge_read", {31'b0, mem_read}, 32'd0);
        checkOutput("sb_merge_wdata", mem_wdata, 32'hDEADABEF);
        checkOutput("sb_merge_addr", mem_addr, 32'd1);
        applyStimulus(1'b1, 3'b001, 32'h6, 32'hFFFF1234, 1'b0, 32'h0, 3, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("sh_merge_wdata", mem_wdata, 32'h1234ABEF);
        applyStimulus(1'b0, 3'b010, 32'h4, 32'h0, 1'b0, 32'h1234ABEF, 2, 1'b1, 1'b0);
        checkOutput("mem_word1", mem[1], 32'h1234ABEF);

        // Faulting requests: one-cycle fault response, no strobes
        applyStimulus(1'b0, 3'b010, 32'h2,  32'h0, 1'b1, 32'h0, 1, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'b001, 32'h3,  32'h0, 1'b1, 32'h0, 1, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'b010, 32'h80, 32'h55555555, 1'b1, 32'h0, 1, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'b011, 32'h0,  32'h0, 1'b1, 32'h0, 1, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'b100, 32'h0,  32'h0, 1'b1, 32'h0, 1, 1'b0, 1'b0);
        checkOutput("fault_no_write", mem[0], 32'h0000006E);

        // Back-to-back: load accepted in the response cycle of a store, held through ACCESS
        applyStimulus(1'b1, 3'b010, 32'hC, 32'h11223344, 1'b0, 32'h0, 2, 1'b0, 1'b1);
        checkOutput("ready_in_access", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        checkOutput("b2b_resp_cycle", {31'b0, resp_valid}, 32'd1);
        checkOutput("b2b_ready", {31'b0, req_ready}, 32'd1);
        driveReq(1'b0, 3'b010, 32'hC, 32'h0);
        sb_q.push_back('{fault: 1'b0, rdata: 32'h11223344, due: 32'(cyc + 2)});
        @(posedge clk);
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Reset while the merge write is pending
        driveReq(1'b1, 3'b000, 32'h0, 32'h000000CC);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_sb_read", {31'b0, mem_read}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_merge_no_write", {31'b0, mem_write}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_merge_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rst_merge_mem", mem[0], 32'h0000006E);
        checkOutput("rst_merge_resp", {31'b0, resp_valid}, 32'd0);
        repeat (3) @(negedge clk);

        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("queue_drain", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
